audio_sample_fifo: RTL and testbench
====================================

Name: audio_sample_fifo

Overview:
Rate-paced PCM sample buffer between a sample producer and the one-bit audio DAC path. A producer pushes signed 16-bit samples over a valid/ready stream. The block buffers them in a FIFO and releases exactly one sample per sample-rate tick, derived fractionally from the system clock. Its held output drives the DAC input and the pcm_out observation port. It handles underrun, flush and per-tick strobes so software or DMA can stream audio without cycle-exact timing.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
SAMPLE_HZ, 48000, output sample rate in Hz; must satisfy 0 < SAMPLE_HZ <= CLK_HZ
FIFO_AW, 6, FIFO address width; depth = 2**FIFO_AW entries
RAMP_STEP, 64, magnitude decrement per tick used by the optional ramp feature

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = generate ticks and consume samples; 0 = paused
flush  in  1  synchronous pulse; empties the FIFO
s_data  in  16  signed input sample
s_valid  in  1  input sample valid
s_ready  out  1  FIFO can accept a sample
sample_out  out  16  signed held output sample, to the DAC
sample_tick  out  1  one-cycle strobe when sample_out updates
level  out  FIFO_AW+1  current FIFO occupancy
underrun  out  1  sticky; set when a tick finds the FIFO empty
underrun_clr  in  1  synchronous pulse; clears underrun

Behaviour:
- Reset (async assert, sync-released use): FIFO empty, level=0, sample_out=0, sample_tick=0, underrun=0, phase accumulator=0. s_ready=1 once reset is released.
- Tick generator: 32-bit accumulator acc.
  - Each clk with enable=1: if acc + SAMPLE_HZ >= CLK_HZ, then acc <= acc + SAMPLE_HZ - CLK_HZ and tick=1; else acc <= acc + SAMPLE_HZ.
  - enable=0: acc holds, no ticks.
  - Long-run tick rate is exactly SAMPLE_HZ, with no cumulative drift.
- Push: s_valid && s_ready writes s_data at the write pointer. s_ready = (level != 2**FIFO_AW), a registered-state combinational output. Pointers are FIFO_AW+1 bits and wrap naturally.
- Pop on tick, with FIFO non-empty: sample_out <= head entry, read pointer advances, sample_tick=1 in the same cycle sample_out changes.
- Tick with FIFO empty:
  - underrun <= 1.
  - sample_out <= 0, or ramps when the optional feature is enabled.
  - sample_tick=1 still pulses.
- Simultaneous push and pop: level unchanged.
  - Push into a full FIFO during a pop cycle is not accepted; s_ready reflects the pre-pop state.
  - Push into an empty FIFO on a tick cycle is not visible to that tick; the tick counts as an underrun.
- flush: read pointer = write pointer and level=0 next cycle.
  - A push in the same cycle is discarded.
  - A tick in the same cycle uses the pre-flush head.
  - sample_out and underrun are unaffected.
- underrun_clr and an underrun event in the same cycle: set wins.
- enable deasserted mid-stream: FIFO contents and sample_out are held. Resuming continues from the held acc value.
- level: write-minus-read pointer difference, range 0..2**FIFO_AW.
- Storage: inferred RAM with a registered read, or distributed registers. Pop latency from tick to sample_out is fixed at 1 clk, with sample_tick aligned to the update.

Optional Feature:
Macro AUDIO_FIFO_RAMP_EN.
- Defined: on an underrun tick, sample_out moves toward 0 by RAMP_STEP, using saturating arithmetic so it never crosses 0 and never overflows. Once it reaches 0 it stays at 0. The next real sample replaces it immediately. This avoids clicks.
- Undefined: an underrun tick forces sample_out=0 at once. RAMP_STEP is unused.

Test Plan:
- Pacing: CLK_HZ=100, SAMPLE_HZ=25, enable=1 -> sample_tick every 4th clk exactly; 100 clks -> 25 ticks. CLK_HZ=100, SAMPLE_HZ=30 -> 30 ticks per 100 clks, with gaps of 3 or 4 clks.
- Ordering: push 0x0001, 0x7FFF, 0x8000, 0xFFFF -> sample_out shows the same sequence on successive ticks; level goes 4,3,2,1,0.
- Full: FIFO_AW=2; push 5 samples with no ticks -> s_ready=0 after 4 pushes, level=4, the 5th is held off. One tick -> s_ready=1 and the 5th is accepted.
- Underrun: empty FIFO, tick -> underrun=1, sample_out=0 (ramp disabled). underrun_clr -> 0. Underrun and clr in the same cycle -> stays 1.
- Ramp (AUDIO_FIFO_RAMP_EN, RAMP_STEP=64): last sample 200, then empty ticks -> 136, 72, 8, 0, 0. Last sample -100 -> -36, 0.
- Reset/flush: assert rst_n=0 mid-stream -> outputs 0 and level 0 immediately (async). flush with 3 entries -> level=0, next tick flags underrun.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: paced PCM sample buffer feeding the one-bit DAC path.
// Samples are pushed over a valid/ready stream into a FIFO and released one
// per sample-rate tick. Ticks come from a fractional phase accumulator, so the
// long-run rate is exactly SAMPLE_HZ and does not drift.
// Optional feature: define AUDIO_FIFO_RAMP_EN so that underrun ticks ramp
// sample_out toward zero by RAMP_STEP instead of forcing it to zero at once.
module audio_sample_fifo #(
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int FIFO_AW   = 6,
  parameter int RAMP_STEP = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  input  logic signed [15:0]  s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic signed [15:0]  sample_out,
  output logic                sample_tick,
  output logic [FIFO_AW:0]    level,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [32:0] CLK_W    = 33'(CLK_HZ);
  localparam logic [32:0] SAMPLE_W = 33'(SAMPLE_HZ);
  localparam logic signed [16:0] RAMP_S = 17'(RAMP_STEP);
`ifdef AUDIO_FIFO_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic [31:0]        acc_reg;
  logic [32:0]        acc_sum;
  logic               tick;
  logic [FIFO_AW:0]   wr_ptr_reg;
  logic [FIFO_AW:0]   rd_ptr_reg;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic signed [15:0] mem [DEPTH];
  logic signed [15:0] sample_out_reg;
  logic signed [15:0] fill_value;
  logic signed [16:0] cur_wide;
  logic               sample_tick_reg;
  logic               underrun_reg;

  // Accumulator sum is one bit wider so acc + SAMPLE_HZ can never wrap.
  assign acc_sum    = {1'b0, acc_reg} + SAMPLE_W;
  assign tick       = enable && (acc_sum >= CLK_W);

  // Occupancy is the pointer difference; MSB set means exactly DEPTH entries.
  assign level      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (level == '0);
  assign s_ready    = ~level[FIFO_AW];
  assign push       = s_valid && s_ready && !flush;
  assign pop        = tick && !fifo_empty;

  assign sample_out  = sample_out_reg;
  assign sample_tick = sample_tick_reg;
  assign underrun    = underrun_reg;

  // Phase accumulator: advance by SAMPLE_HZ, wrap by CLK_HZ on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= tick ? 32'(acc_sum - CLK_W) : acc_sum[31:0];
    end
  end

  // Sample storage; write-only port, no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[FIFO_AW-1:0]] <= s_data;
    end
  end

  // Pointers; flush snaps read onto the pre-push write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (flush) begin
        rd_ptr_reg <= wr_ptr_reg;
      end else if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Value loaded on an underrun tick: zero, or a saturating step toward zero.
  always_comb begin
    fill_value = '0;
    cur_wide   = 17'(sample_out_reg);
    if (RAMP_ON) begin
      if (cur_wide > RAMP_S) begin
        fill_value = 16'(cur_wide - RAMP_S);
      end else if (cur_wide < -RAMP_S) begin
        fill_value = 16'(cur_wide + RAMP_S);
      end
    end
  end

  // Output register: registered read of the head on a tick, strobe aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out_reg  <= '0;
      sample_tick_reg <= 1'b0;
    end else begin
      sample_tick_reg <= tick;
      if (tick) begin
        sample_out_reg <= fifo_empty ? fill_value : mem[rd_ptr_reg[FIFO_AW-1:0]];
      end
    end
  end

  // Sticky underrun flag; a new underrun beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_reg <= 1'b0;
    end else if (tick && fifo_empty) begin
      underrun_reg <= 1'b1;
    end else if (underrun_clr) begin
      underrun_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Testbench for audio_sample_fifo: directed phases plus randomized traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_audio_sample_fifo;

  localparam int CHZ  = 100;
  localparam int SHZ  = 30;
  localparam int AW   = 2;
  localparam int DEPTH = 1 << AW;
  localparam int RSTEP = 64;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               flush;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] sample_out;
  logic               sample_tick;
  logic [AW:0]        level;
  logic               underrun;
  logic               underrun_clr;

  int n_checks;
  int n_pass;

  // Reference model state
  int                 m_acc;
  logic signed [15:0] m_q[$];
  logic signed [15:0] m_out;
  bit                 m_und;
  bit                 m_tick;
  bit                 m_pushed;
  bit                 verbose;

  audio_sample_fifo #(
    .CLK_HZ(CHZ), .SAMPLE_HZ(SHZ), .FIFO_AW(AW), .RAMP_STEP(RSTEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sample_out(sample_out), .sample_tick(sample_tick), .level(level),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic signed [15:0] underrun_value(input logic signed [15:0] x);
    int xi;
    xi = x;
`ifdef AUDIO_FIFO_RAMP_EN
    if (xi > RSTEP) return 16'(xi - RSTEP);
    if (xi < -RSTEP) return 16'(xi + RSTEP);
`endif
    return 16'sd0;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_q.delete();
    m_out = '0;
    m_und = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("sample_out", 32'(unsigned'(sample_out)), 32'(unsigned'(m_out)));
    check_val("sample_tick", 32'(sample_tick), 32'(m_tick));
    check_val("level", 32'(level), 32'(m_q.size()));
    check_val("s_ready", 32'(s_ready), 32'(m_q.size() < DEPTH));
    check_val("underrun", 32'(underrun), 32'(m_und));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit en, input bit v, input logic [15:0] d, input bit fl, input bit cl);
    bit ready;
    bit empty;
    enable = en; s_valid = v; s_data = d; flush = fl; underrun_clr = cl;
    ready = (m_q.size() < DEPTH);
    empty = (m_q.size() == 0);
    m_tick = en && (m_acc + SHZ >= CHZ);
    if (en) m_acc = m_tick ? m_acc + SHZ - CHZ : m_acc + SHZ;
    if (m_tick) begin
      if (!empty) m_out = m_q.pop_front();
      else m_out = underrun_value(m_out);
    end
    if (m_tick && empty) m_und = 1'b1;
    else if (cl) m_und = 1'b0;
    m_pushed = 1'b0;
    if (fl) m_q.delete();
    else if (v && ready) begin
      m_q.push_back(d);
      m_pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (verbose && (m_tick || m_pushed))
      $display("txn t=%0t push=%0d data=%h tick=%0d out=%h level=%0d underrun=%0d",
               $time, m_pushed, d, sample_tick, sample_out, level, underrun);
  endtask

  initial begin
    int ticks;
    int last_tick;
    int gap;
    int guard;
    logic [15:0] seq [4];
    n_checks = 0; n_pass = 0; verbose = 1'b1;
    enable = 0; flush = 0; s_data = '0; s_valid = 0; underrun_clr = 0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs();

    // Ordering and full: four boundary samples, then a fifth held off while paused.
    seq[0] = 16'h0001; seq[1] = 16'h7FFF; seq[2] = 16'h8000; seq[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) cyc(0, 1, seq[i], 0, 0);
    cyc(0, 1, 16'h1234, 0, 0);
    check_val("fifth_held", 32'(m_pushed), 32'(0));
    guard = 0;
    do begin
      cyc(1, 1, 16'h1234, 0, 0);
      guard++;
    end while (!m_pushed && guard < 20);
    check_val("fifth_taken", 32'(m_pushed), 32'(1));
    // Drain, run into underrun, then clear and clear-vs-set collisions.
    for (int i = 0; i < 30; i++) cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 1);
    guard = 0;
    while (!(m_acc + SHZ >= CHZ) && guard < 10) begin
      cyc(1, 0, '0, 0, 0);
      guard++;
    end
    cyc(1, 0, '0, 0, 1);
    check_val("clr_vs_set", 32'(underrun), 32'(1));

    // Pacing: exactly 30 ticks per 100 clocks, gaps of 3 or 4.
    ticks = 0; last_tick = -1;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, '0, 0, 0);
      if (sample_tick) begin
        if (last_tick >= 0) begin
          gap = i - last_tick;
          check_val("tick_gap", 32'(gap >= 3 && gap <= 4), 32'(1));
        end
        last_tick = i;
        ticks++;
      end
    end
    check_val("ticks_per_100", 32'(ticks), 32'(SHZ));

    // Flush with three entries, then the next tick must underrun.
    cyc(0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'(16'h0100 + i), 0, 0);
    cyc(0, 1, 16'h5555, 1, 0);
    check_val("flush_level", 32'(level), 32'(0));
    for (int i = 0; i < 6; i++) cyc(1, 0, '0, 0, 0);
    check_val("flush_underrun", 32'(underrun), 32'(1));

    // Randomized traffic.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), 16'($urandom),
          ($urandom_range(0, 60) == 0), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-stream with data in flight.
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'(16'h0A00 + i), 0, 0);
    cyc(1, 0, '0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1, 1, 16'($urandom), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
